// File: rtl/axi_stream_join_pkg.sv
// ----------------------------------------------------------------------------
// axi_stream_pkg
//   Shared definitions for the AXI-stream join slice.
//   - STALL_CNT_W_DEFAULT : default width of the alignment-stall counter
//   - slice_lo()          : low bit index of branch idx inside a flattened
//                           bus of width-bit slices, i.e. [idx*width +: width]
// ----------------------------------------------------------------------------
package axi_stream_pkg;

    localparam int STALL_CNT_W_DEFAULT = 16;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/axi_stream_join_if.sv
// ----------------------------------------------------------------------------
// axi_stream_join_if
//   Handshake bundle for the N-way AXI-stream join.
//   Source side (N branches):
//     valid_src[N], ready_src[N], data_src[N*DATA_W], last_src[N]
//     branch i payload lives in data_src[i*DATA_W +: DATA_W]
//   Destination side (one joined stream):
//     valid_dst, ready_dst, data_dst[N*DATA_W], last_dst
//   Modports:
//     slave  : the join block itself (consumes branches, produces joined beat)
//     master : the surrounding environment (drives branches, sinks the beat)
// ----------------------------------------------------------------------------
interface axi_stream_join_if #(
    parameter int N_INPUTS = 2,
    parameter int DATA_W   = 64
) ();

    logic [N_INPUTS-1:0]        valid_src;
    logic [N_INPUTS-1:0]        ready_src;
    logic [N_INPUTS*DATA_W-1:0] data_src;
    logic [N_INPUTS-1:0]        last_src;

    logic                       valid_dst;
    logic                       ready_dst;
    logic [N_INPUTS*DATA_W-1:0] data_dst;
    logic                       last_dst;

    modport slave (
        input  valid_src,
        output ready_src,
        input  data_src,
        input  last_src,
        output valid_dst,
        input  ready_dst,
        output data_dst,
        output last_dst
    );

    modport master (
        output valid_src,
        input  ready_src,
        output data_src,
        output last_src,
        input  valid_dst,
        output ready_dst,
        input  data_dst,
        input  last_dst
    );

endinterface

// File: rtl/axi_stream_join_hold_reg.sv
// ----------------------------------------------------------------------------
// axi_stream_hold_reg
//   Single-entry holding register for one join branch.
//   Ports:
//     aclk, aresetn : clock, asynchronous active-low reset
//     load          : capture d_data/d_last this cycle (entry full next cycle)
//     unload        : joined beat consumed; entry empties unless load is set
//     d_data/d_last : incoming branch payload and TLAST
//     full          : entry holds a beat
//     q_data/q_last : held payload and TLAST
// ----------------------------------------------------------------------------
module axi_stream_hold_reg #(
    parameter int DATA_W = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic              unload,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_last,
    output logic              full,
    output logic [DATA_W-1:0] q_data,
    output logic              q_last
);

    // Load wins over unload: a same-cycle release and capture keeps the
    // entry full with the new beat, which is what gives 1 beat/cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // Payload is don't-care while empty; cleared on reset only to keep
    // simulation free of X.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q_data <= '0;
            q_last <= 1'b0;
        end else if (load) begin
            q_data <= d_data;
            q_last <= d_last;
        end
    end

endmodule

// File: rtl/axi_stream_join.sv
// ----------------------------------------------------------------------------
// axi_stream_join
//   Re-joins N_INPUTS AXI-stream branches into one stream: one beat from every
//   branch is presented downstream as a single concatenated beat. Each branch
//   has a one-entry holding register so an early branch may run one beat
//   ahead while later branches catch up.
//   Ports:
//     aclk, aresetn      : clock, asynchronous active-low reset
//     bus (slave)        : branch inputs and joined output (see interface)
//     err_last_mismatch  : one-cycle pulse, the cycle after a joined beat whose
//                          branch TLASTs disagreed (beat is still delivered)
//     stall_cnt          : saturating count of cycles with a partial set held
//     stall_clr          : synchronous clear of stall_cnt (beats increment)
// ----------------------------------------------------------------------------
module axi_stream_join
    import axi_stream_pkg::*;
#(
    parameter int N_INPUTS    = 2,
    parameter int DATA_W      = 64,
    parameter int STALL_CNT_W = STALL_CNT_W_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_stream_join_if.slave       bus,
    output logic                   err_last_mismatch,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [N_INPUTS-1:0]        full;
    logic [N_INPUTS-1:0]        hold_last;
    logic [N_INPUTS*DATA_W-1:0] hold_data;
    logic [N_INPUTS-1:0]        load;
    logic [N_INPUTS-1:0]        ready_int;
    logic                       all_full;
    logic                       any_full;
    logic                       fire;
    logic                       last_mixed;
    logic                       partial;

    assign all_full = &full;
    assign any_full = |full;
    assign fire     = all_full & bus.ready_dst;

    // A full entry may accept again only in the cycle its beat leaves, so
    // ready depends combinationally on ready_dst; valid_dst does not depend
    // on any source input.
    assign ready_int     = ~full | {N_INPUTS{fire}};
    assign bus.ready_src = ready_int;
    assign load          = bus.valid_src & ready_int;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_hold
        axi_stream_hold_reg #(
            .DATA_W (DATA_W)
        ) u_hold (
            .aclk    (aclk),
            .aresetn (aresetn),
            .load    (load[i]),
            .unload  (fire),
            .d_data  (bus.data_src[slice_lo(i, DATA_W) +: DATA_W]),
            .d_last  (bus.last_src[i]),
            .full    (full[i]),
            .q_data  (hold_data[slice_lo(i, DATA_W) +: DATA_W]),
            .q_last  (hold_last[i])
        );
    end

    assign bus.valid_dst = all_full;
    assign bus.data_dst  = hold_data;
    assign bus.last_dst  = &hold_last;

    assign last_mixed = (|hold_last) & ~(&hold_last);
    assign partial    = any_full & ~all_full;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_last_mismatch <= 1'b0;
        end else begin
            err_last_mismatch <= fire & last_mixed;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (partial) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
